// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared op codes, FSM states and byte-lane helpers for dmem_ctrl
package dmem_pkg;

    localparam logic [2:0] OP_B  = 3'b000;
    localparam logic [2:0] OP_H  = 3'b001;
    localparam logic [2:0] OP_W  = 3'b010;
    localparam logic [2:0] OP_BU = 3'b100;
    localparam logic [2:0] OP_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, LOAD, MERGE, RESP} state_t;

    function automatic logic access_err(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            OP_B, OP_BU: return 1'b0;
            OP_H, OP_HU: return lane[0];
            OP_W:        return lane != 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [2:0] op,
                                                 input logic [1:0] lane);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            OP_B:    return {{24{sh[7]}}, sh[7:0]};
            OP_BU:   return {24'h0, sh[7:0]};
            OP_H:    return {{16{sh[15]}}, sh[15:0]};
            OP_HU:   return {16'h0, sh[15:0]};
            default: return word;
        endcase
    endfunction

    // op[1:0]==01 covers both halfword encodings; everything else sub-word is a byte
    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [15:0] data,
                                               input logic [2:0] op, input logic [1:0] lane);
        logic [31:0] mask;
        logic [31:0] ins;
        if (op[1:0] == 2'b01) begin
            mask = 32'h0000_FFFF << {lane, 3'b000};
            ins  = {16'h0, data} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            ins  = {24'h0, data[7:0]} << {lane, 3'b000};
        end
        return (old & ~mask) | (ins & mask);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port synchronous word RAM, read-first, no reset on contents
module dmem_ram
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clock,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] ram [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                ram[addr] <= wdata;
            end
            rdata <= ram[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - RV32I load/store controller over a word RAM; DMEM_TOHOST_EN adds a tohost register
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 15,
    parameter logic [31:0] TOHOST_ADDR = 32'hFFFF_FFF0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_TOHOST_EN
    ,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
`endif
);

    state_t                state;
    logic [2:0]            op_q;
    logic [1:0]            lane_q;
    logic [15:0]           wdata_q;
    logic [ADDR_WIDTH-1:0] widx_q;
    logic                  err_q;
    logic                  accept;
    logic                  bad;
    logic                  is_th;
    logic                  ram_en;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [31:0]           load_word;
    logic                  unused_bits;

    assign accept      = req_valid && req_ready;
    assign unused_bits = ^{req_addr[31:ADDR_WIDTH+2], TOHOST_ADDR};

`ifdef DMEM_TOHOST_EN
    logic th_q;
    assign is_th     = req_addr[31:2] == TOHOST_ADDR[31:2];
    assign bad       = access_err(req_op, req_addr[1:0]) || (is_th && req_op != OP_W);
    assign load_word = th_q ? tohost_data : ram_rdata;
`else
    assign is_th     = 1'b0;
    assign bad       = access_err(req_op, req_addr[1:0]);
    assign load_word = ram_rdata;
`endif

    // Accept cycle drives the RAM straight from the request; MERGE replays the latched word
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = req_addr[ADDR_WIDTH+1:2];
        ram_wdata = req_wdata;
        if (state == IDLE) begin
            ram_en = accept && !bad && !is_th;
            ram_we = ram_en && req_we && (req_op == OP_W) && !reset;
        end else if (state == MERGE) begin
            ram_en    = !reset;
            ram_we    = !reset;
            ram_addr  = widx_q;
            ram_wdata = lane_merge(ram_rdata, wdata_q, op_q, lane_q);
        end
    end

    dmem_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clock (clock),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'h0;
            op_q      <= OP_B;
            lane_q    <= 2'b00;
            wdata_q   <= 16'h0;
            widx_q    <= '0;
            err_q     <= 1'b0;
`ifdef DMEM_TOHOST_EN
            th_q         <= 1'b0;
            tohost_valid <= 1'b0;
            tohost_data  <= 32'h0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= req_op;
                        lane_q    <= req_addr[1:0];
                        wdata_q   <= req_wdata[15:0];
                        widx_q    <= req_addr[ADDR_WIDTH+1:2];
                        err_q     <= bad;
                        req_ready <= 1'b0;
                        if (bad || (req_we && req_op == OP_W)) begin
                            state <= RESP;
                        end else if (req_we) begin
                            state <= MERGE;
                        end else begin
                            state <= LOAD;
                        end
`ifdef DMEM_TOHOST_EN
                        th_q <= is_th;
                        if (!bad && is_th && req_we) begin
                            tohost_valid <= 1'b1;
                            tohost_data  <= req_wdata;
                        end
`endif
                    end
                end
                LOAD: begin
                    rsp_rdata <= lane_extract(load_word, op_q, lane_q);
                    rsp_valid <= 1'b1;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                MERGE: begin
                    state <= RESP;
                end
                default: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= err_q;
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb/tb_dmem_ctrl.sv - directed self-checking bench for dmem_ctrl
module tb_dmem_ctrl;
    import dmem_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
`ifdef DMEM_TOHOST_EN
    logic        tohost_valid;
    logic [31:0] tohost_data;
`endif

    int checks = 0;
    int errors = 0;

    dmem_ctrl dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
`ifdef DMEM_TOHOST_EN
        ,
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request, scramble inputs after accept, then time the response
    task automatic issue(input string tag, input logic we, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic exp_err, input logic [31:0] exp_rdata);
        int lat;
        int busy;
        check({tag, "_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_op    = 3'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat  = 0;
        busy = 0;
        while (!rsp_valid && lat < 8) begin
            if (!req_ready) busy++;
            @(posedge clock); #1;
            lat++;
        end
        check({tag, "_lat"},   32'(lat),     32'(exp_lat));
        check({tag, "_busy"},  32'(busy),    32'(exp_lat));
        check({tag, "_err"},   32'(rsp_err), 32'(exp_err));
        check({tag, "_rdata"}, rsp_rdata,    exp_rdata);
        @(posedge clock); #1;
        check({tag, "_pulse"}, 32'({rsp_valid, rsp_err}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_op    = 3'b000;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        dut.u_ram.ram[15'h0040] = 32'h8081_7F80;
        dut.u_ram.ram[15'h0080] = 32'h1122_3344;
        dut.u_ram.ram[15'h00C0] = 32'h0000_0000;
        dut.u_ram.ram[15'h7FFC] = 32'hCAFE_0000;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_ready", 32'(req_ready), 32'd1);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_rdata", rsp_rdata,      32'h0);

        issue("lb",  1'b0, OP_B,  32'h100, 32'h0, 1, 1'b0, 32'hFFFF_FF80);
        issue("lbu", 1'b0, OP_BU, 32'h101, 32'h0, 1, 1'b0, 32'h0000_007F);
        issue("lh",  1'b0, OP_H,  32'h102, 32'h0, 1, 1'b0, 32'hFFFF_8081);
        issue("lhu", 1'b0, OP_HU, 32'h102, 32'h0, 1, 1'b0, 32'h0000_8081);

        issue("sb", 1'b1, OP_B, 32'h201, 32'hFFFF_FFAB, 2, 1'b0, 32'h0000_8081);
        check("sb_mem", dut.u_ram.ram[15'h0080], 32'h1122_AB44);
        issue("sh", 1'b1, OP_H, 32'h202, 32'h1234_BEEF, 2, 1'b0, 32'h0000_8081);
        check("sh_mem", dut.u_ram.ram[15'h0080], 32'hBEEF_AB44);

        issue("sw",       1'b1, OP_W, 32'h300,    32'hDEAD_BEEF, 1, 1'b0, 32'h0000_8081);
        issue("lw_alias", 1'b0, OP_W, 32'h2_0300, 32'h0,         1, 1'b0, 32'hDEAD_BEEF);
        issue("lw",       1'b0, OP_W, 32'h300,    32'h0,         1, 1'b0, 32'hDEAD_BEEF);

        issue("lw_mis",  1'b0, OP_W,   32'h102, 32'h0,         1, 1'b1, 32'hDEAD_BEEF);
        issue("sh_mis",  1'b1, OP_H,   32'h103, 32'hFFFF_FFFF, 1, 1'b1, 32'hDEAD_BEEF);
        issue("op011",   1'b0, 3'b011, 32'h100, 32'h0,         1, 1'b1, 32'hDEAD_BEEF);
        issue("st_op111", 1'b1, 3'b111, 32'h200, 32'h0,        1, 1'b1, 32'hDEAD_BEEF);
        check("err_mem_100", dut.u_ram.ram[15'h0040], 32'h8081_7F80);
        check("err_mem_200", dut.u_ram.ram[15'h0080], 32'hBEEF_AB44);

        check("mrg_rst_ready0", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_op    = OP_B;
        req_addr  = 32'h200;
        req_wdata = 32'h0000_0055;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mrg_rst_ready", 32'(req_ready), 32'd1);
        check("mrg_rst_valid", 32'(rsp_valid), 32'd0);
        check("mrg_rst_rdata", rsp_rdata,      32'h0);
        @(posedge clock); #1;
        check("mrg_rst_valid2", 32'(rsp_valid), 32'd0);
        check("mrg_rst_mem", dut.u_ram.ram[15'h0080], 32'hBEEF_AB44);

        for (int i = 0; i < 3; i++) begin
            req_we    = 1'b1;
            req_op    = OP_W;
            req_addr  = 32'h200;
            req_wdata = $urandom;
            @(posedge clock); #1;
            check("idle_valid", 32'(rsp_valid), 32'd0);
        end
        check("idle_mem", dut.u_ram.ram[15'h0080], 32'hBEEF_AB44);

`ifdef DMEM_TOHOST_EN
        check("th_rst", 32'(tohost_valid), 32'd0);
        issue("th_sw", 1'b1, OP_W, 32'hFFFF_FFF0, 32'h1, 1, 1'b0, 32'h0);
        check("th_valid", 32'(tohost_valid), 32'd1);
        check("th_data",  tohost_data,       32'h1);
        check("th_ram",   dut.u_ram.ram[15'h7FFC], 32'hCAFE_0000);
        issue("th_lw", 1'b0, OP_W, 32'hFFFF_FFF0, 32'h0, 1, 1'b0, 32'h1);
        issue("th_sb", 1'b1, OP_B, 32'hFFFF_FFF1, 32'h77, 1, 1'b1, 32'h1);
        check("th_data2", tohost_data, 32'h1);
`else
        issue("th_sw", 1'b1, OP_W, 32'hFFFF_FFF0, 32'h1, 1, 1'b0, 32'h0);
        check("th_ram", dut.u_ram.ram[15'h7FFC], 32'h0000_0001);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
